// File: rtl/ibex_prefetch_queue.sv
// Instruction prefetch queue: issues word-aligned fetch requests on the
// instruction bus, tracks up to NumReqs in-flight requests in order, and
// buffers returned instructions in a FifoDepth-entry output FIFO. A branch
// redirects the fetch pointer, discards everything in flight and flushes
// the FIFO. Responses reach valid_o one cycle after rvalid.
module ibex_prefetch_queue #(
    parameter int unsigned NumReqs   = 2,
    parameter int unsigned FifoDepth = 3,
    parameter bit          ResetAll  = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_i,
    input  logic                         branch_i,
    input  logic [31:0]                  addr_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [31:0]                  rdata_o,
    output logic [31:0]                  addr_o,
    output logic                         err_o,
    output logic                         instr_req_o,
    input  logic                         instr_gnt_i,
    output logic [31:0]                  instr_addr_o,
    input  logic [31:0]                  instr_rdata_i,
    input  logic                         instr_err_i,
    input  logic                         instr_pmp_err_i,
    input  logic                         instr_rvalid_i,
    output logic                         busy_o,
    output logic [$clog2(NumReqs+1)-1:0] outstanding_o
);

    localparam int unsigned OutW = $clog2(NumReqs + 1);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    // One in-flight bus request, oldest at index 0.
    typedef struct packed {
        logic [31:0] addr;
        logic        pmp;
        logic        discard;
    } oq_entry_t;

    // One returned instruction waiting for the consumer, oldest at index 0.
    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } fifo_entry_t;

    // Control state (always reset)
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic          ptr_valid_q, ptr_valid_d;
    logic          hold_q, hold_d;
    logic          hold_disc_q, hold_disc_d;
    logic [OutW-1:0] oq_cnt_q, oq_cnt_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;

    // Datapath state (reset only when ResetAll is set)
    logic [31:0]   hold_addr_q, hold_addr_d;
    oq_entry_t     oq_q   [NumReqs];
    oq_entry_t     oq_d   [NumReqs];
    fifo_entry_t   fifo_q [FifoDepth];
    fifo_entry_t   fifo_d [FifoDepth];

    // Combinational helpers
    logic [31:0]   branch_addr;
    logic [31:0]   next_addr;
    int            fifo_term;
    logic          can_req;
    logic          accept;
    logic          disc_cur;
    oq_entry_t     head;
    logic          complete;
    logic          complete_keep;
    logic          oq_push;
    int            oq_wr_idx;
    logic          fifo_pop;
    logic          fifo_wr;
    int            fifo_wr_idx;
    fifo_entry_t   new_entry;

    // Request side: decide whether to issue, what address, and how the pointer moves.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
        branch_addr = addr_i & 32'hFFFF_FFFC;
        next_addr   = branch_i ? branch_addr : fetch_addr_q;
        // The FIFO is flushed by a branch, so its occupancy does not limit the redirect request.
        fifo_term   = branch_i ? 0 : int'(fifo_cnt_q);
        can_req     = req_i && (ptr_valid_q || branch_i)
                      && (int'(oq_cnt_q) < int'(NumReqs))
                      && ((int'(oq_cnt_q) + fifo_term) < int'(FifoDepth));

        // A request already on the bus is held unchanged until it is accepted.
        instr_req_o  = hold_q || can_req;
        instr_addr_o = hold_q ? hold_addr_q : next_addr;
        // Only a held request can predate a branch; a fresh one targets the new address.
        disc_cur     = hold_q && (hold_disc_q || branch_i);
        accept       = instr_req_o && (instr_gnt_i || instr_pmp_err_i);

        hold_d      = instr_req_o && !accept;
        hold_addr_d = instr_addr_o;
        hold_disc_d = disc_cur;

        fetch_addr_d = next_addr;
        if (accept && !disc_cur) begin
            fetch_addr_d = instr_addr_o + 32'd4;
        end
        ptr_valid_d = ptr_valid_q || branch_i;
    end

    // Outstanding queue: in-order completion, push on acceptance, discard-mark on branch.
    always_comb begin
        head          = oq_q[0];
        complete      = (oq_cnt_q != '0) && (head.pmp || instr_rvalid_i);
        complete_keep = complete && !head.discard && !branch_i;

        oq_d = oq_q;
        for (int i = 0; i < int'(NumReqs); i++) begin
            oq_d[i].discard = oq_q[i].discard || branch_i;
        end
        if (complete) begin
            for (int i = 0; i < int'(NumReqs) - 1; i++) begin
                oq_d[i] = oq_d[i + 1];
            end
        end

        oq_wr_idx = int'(oq_cnt_q) - int'(complete);
        oq_push   = accept && (oq_wr_idx < int'(NumReqs));
        if (oq_push) begin
            for (int i = 0; i < int'(NumReqs); i++) begin
                if (i == oq_wr_idx) begin
                    oq_d[i].addr    = instr_addr_o;
                    oq_d[i].pmp     = instr_pmp_err_i;
                    oq_d[i].discard = disc_cur;
                end
            end
        end
        oq_cnt_d = oq_cnt_q - OutW'(complete) + OutW'(oq_push);
    end

    // Output FIFO: flush on branch, otherwise pop-then-write so full + write + pop keeps count.
    always_comb begin
        valid_o     = (fifo_cnt_q != '0) && !branch_i;
        fifo_pop    = valid_o && ready_i;
        fifo_wr_idx = int'(fifo_cnt_q) - int'(fifo_pop);
        fifo_wr     = complete_keep && (fifo_wr_idx < int'(FifoDepth));

        new_entry.rdata = head.pmp ? 32'h0 : instr_rdata_i;
        new_entry.addr  = head.addr;
        new_entry.err   = instr_err_i || head.pmp;

        fifo_d     = fifo_q;
        fifo_cnt_d = fifo_cnt_q;
        if (branch_i) begin
            fifo_cnt_d = '0;
        end else begin
            if (fifo_pop) begin
                for (int i = 0; i < int'(FifoDepth) - 1; i++) begin
                    fifo_d[i] = fifo_d[i + 1];
                end
            end
            if (fifo_wr) begin
                for (int i = 0; i < int'(FifoDepth); i++) begin
                    if (i == fifo_wr_idx) begin
                        fifo_d[i] = new_entry;
                    end
                end
            end
            fifo_cnt_d = fifo_cnt_q - CntW'(fifo_pop) + CntW'(fifo_wr);
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (!rst_ni) begin
            fetch_addr_q <= 32'h0;
            ptr_valid_q  <= 1'b0;
            hold_q       <= 1'b0;
            hold_disc_q  <= 1'b0;
            oq_cnt_q     <= '0;
            fifo_cnt_q   <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            ptr_valid_q  <= ptr_valid_d;
            hold_q       <= hold_d;
            hold_disc_q  <= hold_disc_d;
            oq_cnt_q     <= oq_cnt_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end

    // Datapath registers; contents are only observed behind a nonzero count.
    if (ResetAll) begin : g_data_rst
        // Datapath registers, cleared by reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                hold_addr_q <= 32'h0;
                for (int i = 0; i < int'(NumReqs); i++) begin
                    oq_q[i] <= '0;
                end
                for (int i = 0; i < int'(FifoDepth); i++) begin
                    fifo_q[i] <= '0;
                end
            end else begin
                hold_addr_q <= hold_addr_d;
                oq_q        <= oq_d;
                fifo_q      <= fifo_d;
            end
        end
    end else begin : g_data_nrst
        // Datapath registers without reset.
        // NOTE: storage arrays are left unreset; the counters alone define which entries are valid.
        always_ff @(posedge clk_i) begin
            hold_addr_q <= hold_addr_d;
            oq_q        <= oq_d;
            fifo_q      <= fifo_d;
        end
    end

    assign rdata_o       = fifo_q[0].rdata;
    assign addr_o        = fifo_q[0].addr;
    assign err_o         = fifo_q[0].err;
    assign busy_o        = (oq_cnt_q != '0) || instr_req_o;
    assign outstanding_o = oq_cnt_q;

endmodule

// File: tb/tb_ibex_prefetch_queue.sv
// Self-checking bench for ibex_prefetch_queue: directed sequences for the
// documented scenarios, an alignment/wrap vector table, and a randomized run
// compared every cycle against a queue-based behavioural model.
module tb_ibex_prefetch_queue;

    localparam int NR = 2;
    localparam int FD = 3;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i, branch_i, ready_i;
    logic [31:0] addr_i;
    logic        valid_o, err_o;
    logic [31:0] rdata_o, addr_o;
    logic        instr_req_o, instr_gnt_i;
    logic [31:0] instr_addr_o, instr_rdata_i;
    logic        instr_err_i, instr_pmp_err_i, instr_rvalid_i;
    logic        busy_o;
    logic [$clog2(NR+1)-1:0] outstanding_o;

    ibex_prefetch_queue #(.NumReqs(NR), .FifoDepth(FD), .ResetAll(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
        .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
        .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
        .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .instr_pmp_err_i(instr_pmp_err_i), .instr_rvalid_i(instr_rvalid_i),
        .busy_o(busy_o), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { logic [31:0] addr; bit pmp; bit disc; } m_req_t;
    typedef struct { logic [31:0] rdata; logic [31:0] addr; bit err; } m_out_t;

    m_req_t      m_oq[$];
    m_out_t      m_fifo[$];
    logic [31:0] m_ptr;
    bit          m_ptr_valid, m_hold, m_hold_disc, last_accept;
    logic [31:0] m_hold_addr;
    bit          e_req, e_valid;
    logic [31:0] e_addr;

    task automatic model_reset();
        m_oq.delete();
        m_fifo.delete();
        m_ptr = 32'h0; m_ptr_valid = 0; m_hold = 0; m_hold_disc = 0;
        m_hold_addr = 32'h0; last_accept = 0;
    endtask

    // Mid-cycle: predict the outputs from the model and the current inputs, compare.
    task automatic settle();
        logic [31:0] tgt;
        @(negedge clk);
        tgt    = {addr_i[31:2], 2'b00};
        e_req  = m_hold || (req_i && (m_ptr_valid || branch_i) && m_oq.size() < NR
                 && (m_oq.size() + (branch_i ? 0 : m_fifo.size())) < FD);
        e_addr = m_hold ? m_hold_addr : (branch_i ? tgt : m_ptr);
        e_valid = (m_fifo.size() != 0) && !branch_i;
        check("req", instr_req_o, e_req);
        if (e_req) check("iaddr", instr_addr_o, e_addr);
        check("valid", valid_o, e_valid);
        if (e_valid) begin
            check("addr_o", addr_o, m_fifo[0].addr);
            check("rdata", rdata_o, m_fifo[0].rdata);
            check("err", err_o, m_fifo[0].err);
        end
        check("outstanding", outstanding_o, m_oq.size());
        check("busy", busy_o, (m_oq.size() != 0) || e_req);
    endtask

    // Apply the clock edge to the model, then let the DUT take the same edge.
    task automatic advance();
        bit     acc, dcur, push;
        m_req_t h;
        m_out_t o;
        acc  = e_req && (instr_gnt_i || instr_pmp_err_i);
        dcur = m_hold && (m_hold_disc || branch_i);
        push = 0;
        if (m_oq.size() != 0 && (m_oq[0].pmp || instr_rvalid_i)) begin
            h = m_oq.pop_front();
            if (!h.disc && !branch_i) begin
                o.rdata = h.pmp ? 32'h0 : instr_rdata_i;
                o.addr  = h.addr;
                o.err   = instr_err_i || h.pmp;
                push    = 1;
            end
        end
        if (branch_i) m_fifo.delete();
        else begin
            if (e_valid && ready_i) void'(m_fifo.pop_front());
            if (push) m_fifo.push_back(o);
        end
        if (branch_i) foreach (m_oq[i]) m_oq[i].disc = 1;
        if (acc) m_oq.push_back('{addr: e_addr, pmp: instr_pmp_err_i, disc: dcur});
        if (branch_i) m_ptr = {addr_i[31:2], 2'b00};
        if (acc && !dcur) m_ptr = e_addr + 32'd4;
        m_ptr_valid = m_ptr_valid || branch_i;
        m_hold      = e_req && !acc;
        m_hold_addr = e_addr;
        m_hold_disc = dcur;
        last_accept = acc && !instr_pmp_err_i;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 0; branch_i = 0; addr_i = 32'h0; ready_i = 1;
        instr_gnt_i = 0; instr_rdata_i = 32'h0; instr_err_i = 0;
        instr_pmp_err_i = 0; instr_rvalid_i = 0;
    endtask

    // Return everything in flight and empty the FIFO; bounded by a cycle budget.
    task automatic drain();
        idle_inputs();
        instr_gnt_i = 1;
        for (int k = 0; k < 20; k++) begin
            instr_rvalid_i = (m_oq.size() != 0) && !m_oq[0].pmp;
            instr_rdata_i  = $urandom;
            settle();
            advance();
        end
        idle_inputs();
        settle();
        check("drain_outstanding", outstanding_o, 0);
        check("drain_valid", valid_o, 0);
        advance();
    endtask

    typedef struct { logic [31:0] addr; logic [31:0] exp0; logic [31:0] exp1; } vec_t;
    vec_t vecs[4];

    int  acc_cnt;
    bit  seen;

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFC, 32'h8000_0000};

        idle_inputs();
        model_reset();
        rst_ni = 0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1;

        // Reset state
        settle();
        check("rst_req", instr_req_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        advance();

        // No request before the first redirect
        req_i = 1;
        settle();
        check("no_req_before_branch", instr_req_o, 0);
        advance();

        // Streaming at one word per cycle from 0x100
        instr_gnt_i = 1; ready_i = 1;
        for (int k = 0; k < 8; k++) begin
            branch_i = (k == 0); addr_i = 32'h100;
            instr_rvalid_i = last_accept; instr_rdata_i = $urandom;
            settle();
            check("stream_iaddr", instr_addr_o, 32'h100 + 32'(4 * k));
            if (k >= 2) begin
                check("stream_valid", valid_o, 1);
                check("stream_addr_o", addr_o, 32'h100 + 32'(4 * (k - 2)));
            end
            advance();
        end
        drain();

        // Back-pressure: exactly FifoDepth requests accepted
        acc_cnt = 0;
        req_i = 1; instr_gnt_i = 1; ready_i = 0;
        for (int k = 0; k < 8; k++) begin
            branch_i = (k == 0); addr_i = 32'h100;
            instr_rvalid_i = last_accept; instr_rdata_i = $urandom;
            settle();
            if (instr_req_o && instr_gnt_i) acc_cnt++;
            advance();
        end
        branch_i = 0; instr_rvalid_i = 0;
        settle();
        check("bp_accepts", acc_cnt, 3);
        check("bp_req_low", instr_req_o, 0);
        check("bp_outstanding", outstanding_o, 0);
        check("bp_valid", valid_o, 1);
        advance();

        // Outstanding count 2 -> 1 -> 0 as data arrives
        branch_i = 1; addr_i = 32'h100; req_i = 1; instr_gnt_i = 1; ready_i = 0;
        settle(); advance();
        branch_i = 0;
        settle(); advance();
        settle();
        check("os_two", outstanding_o, 2);
        check("os_req_low", instr_req_o, 0);
        advance();
        req_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h1111_0000;
        settle(); advance();
        instr_rdata_i = 32'h2222_0000;
        settle();
        check("os_one", outstanding_o, 1);
        advance();
        instr_rvalid_i = 0;
        settle();
        check("os_zero", outstanding_o, 0);
        advance();
        drain();

        // Branch with two outstanding: both responses dropped, next output is the target
        req_i = 1; instr_gnt_i = 1; ready_i = 1; branch_i = 1; addr_i = 32'h100;
        settle(); advance();
        branch_i = 0;
        settle(); advance();
        branch_i = 1; addr_i = 32'h400;
        settle();
        check("br_blocked", instr_req_o, 0);
        check("br_valid_low", valid_o, 0);
        advance();
        branch_i = 0; seen = 0;
        for (int k = 0; k < 12; k++) begin
            instr_rvalid_i = (m_oq.size() != 0) && !m_oq[0].pmp;
            instr_rdata_i  = $urandom;
            settle();
            if (valid_o && !seen) begin
                seen = 1;
                check("br_first_addr", addr_o, 32'h400);
            end
            advance();
        end
        check("br_seen", seen, 1);
        drain();

        // PMP error behind an outstanding request
        req_i = 1; instr_gnt_i = 1; branch_i = 1; addr_i = 32'h1FC;
        settle(); advance();
        branch_i = 0; instr_gnt_i = 0; instr_pmp_err_i = 1;
        settle();
        check("pmp_iaddr", instr_addr_o, 32'h200);
        advance();
        req_i = 0; instr_pmp_err_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hDEAD_BEEF;
        settle(); advance();
        instr_rvalid_i = 0;
        settle();
        check("pmp_a0", addr_o, 32'h1FC);
        check("pmp_e0", err_o, 0);
        check("pmp_d0", rdata_o, 32'hDEAD_BEEF);
        advance();
        settle();
        check("pmp_a1", addr_o, 32'h200);
        check("pmp_e1", err_o, 1);
        check("pmp_d1", rdata_o, 32'h0);
        advance();
        drain();

        // Alignment and wrap-around vectors
        foreach (vecs[n]) begin
            req_i = 1; instr_gnt_i = 1; ready_i = 1; branch_i = 1; addr_i = vecs[n].addr;
            settle();
            check("tbl_iaddr0", instr_addr_o, vecs[n].exp0);
            advance();
            branch_i = 0;
            settle();
            check("tbl_iaddr1", instr_addr_o, vecs[n].exp1);
            advance();
            req_i = 0; instr_rvalid_i = 1; instr_rdata_i = vecs[n].exp0 ^ 32'h5A5A_5A5A;
            settle(); advance();
            instr_rdata_i = vecs[n].exp1 ^ 32'h5A5A_5A5A;
            settle();
            check("tbl_out0", addr_o, vecs[n].exp0);
            advance();
            instr_rvalid_i = 0;
            settle();
            check("tbl_out1", addr_o, vecs[n].exp1);
            advance();
            drain();
        end

        // Reset pulse with two outstanding; late responses are ignored
        req_i = 1; instr_gnt_i = 1; branch_i = 1; addr_i = 32'h300;
        settle(); advance();
        branch_i = 0;
        settle(); advance();
        idle_inputs();
        #2 rst_ni = 0;
        #1;
        check("rstp_req", instr_req_o, 0);
        check("rstp_valid", valid_o, 0);
        check("rstp_busy", busy_o, 0);
        check("rstp_outstanding", outstanding_o, 0);
        model_reset();
        @(negedge clk);
        #2 rst_ni = 1;
        @(posedge clk);
        #1;
        instr_rvalid_i = 1; instr_rdata_i = 32'hBAD0_BAD0;
        settle();
        check("rstp_late_os", outstanding_o, 0);
        advance();
        instr_rvalid_i = 0;
        settle();
        check("rstp_late_valid", valid_o, 0);
        advance();

        // Randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            req_i           = ($urandom_range(0, 9) < 8);
            branch_i        = ($urandom_range(0, 19) == 0);
            addr_i          = $urandom;
            ready_i         = ($urandom_range(0, 9) < 7);
            instr_gnt_i     = ($urandom_range(0, 9) < 6);
            instr_pmp_err_i = ($urandom_range(0, 19) == 0);
            instr_rvalid_i  = (m_oq.size() != 0) && !m_oq[0].pmp && ($urandom_range(0, 9) < 6);
            instr_rdata_i   = $urandom;
            instr_err_i     = ($urandom_range(0, 9) == 0);
            settle();
            advance();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_prefetch_queue.md
IBEX_PREFETCH_QUEUE -- requirements
Module: ibex_prefetch_queue

Interface
REQ-001 SHALL have parameter NumReqs, default 2, max outstanding bus requests (legal 1..8).
REQ-002 SHALL have parameter FifoDepth, default 3, output-FIFO entries (legal NumReqs..16).
REQ-003 SHALL have parameter ResetAll, default 0; 1 = datapath registers (addresses, FIFO data) also async-reset to 0.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i in 1, rst_ni in 1.
REQ-005 Fetch-side ports: req_i in 1 fetch enable; branch_i in 1 redirect; addr_i in 32 redirect target.
REQ-006 Output ports: ready_i in 1; valid_o out 1; rdata_o out 32; addr_o out 32 word address; err_o out 1.
REQ-007 Bus ports: instr_req_o out 1; instr_gnt_i in 1; instr_addr_o out 32; instr_rdata_i in 32; instr_err_i in 1; instr_pmp_err_i in 1; instr_rvalid_i in 1.
REQ-008 Status ports: busy_o out 1; outstanding_o out $clog2(NumReqs+1) = current outstanding count.

Function
REQ-009 Fetch pointer: on branch_i loads {addr_i[31:2],2'b00}; +4 per accepted request (gnt or pmp_err); 32-bit wrap 0xFFFFFFFC -> 0x0.
REQ-010 New request allowed when req_i & outstanding < NumReqs & (outstanding + fifo_count) < FifoDepth; in a branch_i cycle the FIFO term counts as 0 and address = aligned addr_i.
REQ-011 instr_addr_o always word aligned ([1:0] = 0).
REQ-012 Once instr_req_o is high, it and instr_addr_o SHALL stay stable until instr_gnt_i or instr_pmp_err_i, regardless of req_i or branch_i.
REQ-013 instr_pmp_err_i counts as acceptance; entry is tagged pmp; no rvalid follows for it.
REQ-014 Outstanding queue: NumReqs in-order entries {addr, pmp, discard}; pushed on acceptance, popped at completion.
REQ-015 Head completes on instr_rvalid_i, or in the cycle it becomes head if tagged pmp; one completion per cycle max.
REQ-016 branch_i sets discard on every outstanding entry and on a pending ungranted request (applied at its grant); completion in the branch cycle is also dropped.
REQ-017 Non-discarded completion writes FIFO {rdata = instr_rdata_i or 0 if pmp, addr, err = instr_err_i | pmp}.
REQ-018 FIFO: valid_o = nonempty & ~branch_i; pop on valid_o & ready_i; branch_i clears all entries (clear beats write and pop).
REQ-019 Simultaneous write and pop on a full FIFO SHALL be legal and keep count.
REQ-020 Completion latency: rvalid in cycle N -> valid_o in N+1 (registered FIFO, no bypass).
REQ-021 busy_o = (outstanding != 0) | instr_req_o.
REQ-022 rvalid with outstanding = 0 SHALL be ignored; counts never underflow or overflow.

Reset
REQ-023 On rst_ni low, asynchronously: instr_req_o 0, valid_o 0, busy_o 0, outstanding_o 0, FIFO empty, queue empty, fetch pointer 0 (ResetAll=1 also zeroes data/addr regs).
REQ-024 Reset mid-operation discards all in-flight state; responses arriving after release with outstanding 0 are ignored.
REQ-025 First request after reset SHALL wait for branch_i (pointer valid only after a redirect).

Verification
REQ-026 Defaults, branch_i to 0x100 + req_i, gnt every cycle, rvalid 1 cycle after gnt, ready_i=1 -> instr_addr_o 0x100,0x104,0x108...; addr_o 0x100 first, one word/cycle steady state.
REQ-027 ready_i=0, FifoDepth=3 -> exactly 3 requests accepted, instr_req_o then low; outstanding_o 2->0 as data arrives.
REQ-028 Two outstanding (0x100,0x104), branch_i to 0x400 -> both rvalids dropped, valid_o low, next addr_o = 0x400.
REQ-029 pmp_err on request for 0x200 behind outstanding 0x1FC -> outputs 0x1FC err_o=0 then 0x200 err_o=1, rdata_o=0, no rvalid.
REQ-030 branch_i to 0x102 -> instr_addr_o 0x100, addr_o 0x100; rst_ni pulse with 2 outstanding -> all outputs 0 next cycle.
